// File: rtl/sop_operand_loader_if.sv
// sop_operand_loader_if: serial operand stream in, parallel dataa/datab vectors out
interface sop_operand_loader_if #(
   parameter int WIDTH = 16,
   parameter int NUM   = 9
);
   logic                 weight_reload;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic                 data_valid;
   logic [NUM*WIDTH-1:0] dataa;
   logic [NUM*WIDTH-1:0] datab;
   logic                 weights_loaded;
   logic                 nan_seen;
   modport master (
      output weight_reload, in_valid, in_data,
      input  in_ready, data_valid, dataa, datab, weights_loaded, nan_seen
   );
   modport slave (
      input  weight_reload, in_valid, in_data,
      output in_ready, data_valid, dataa, datab, weights_loaded, nan_seen
   );
endinterface

// File: rtl/sop_operand_loader.sv
// sop_operand_loader: serial float words to NUM-wide activation/weight vectors; SOP_LOADER_NAN_FLAG_EN adds sticky nan_seen
module sop_operand_loader #(
   parameter int EXP   = 8,
   parameter int MANT  = 7,
   parameter int WIDTH = 1 + EXP + MANT,
   parameter int NUM   = 9
) (
   input logic clock,
   input logic clock_areset_n,
   sop_operand_loader_if.slave bus
);
   localparam int IW = $clog2(NUM);
   typedef enum logic {LOAD_W, RUN} state_t;
   state_t               state;
   logic                 live, fire, last, dv;
   logic [IW-1:0]        idx;
   logic [NUM*WIDTH-1:0] w, a, w_nxt, a_nxt, da, db;
   // live keeps in_ready low until the first clock after reset release
   assign bus.in_ready       = live & ~bus.weight_reload;
   assign fire               = bus.in_valid & bus.in_ready;
   assign last               = fire & (idx == IW'(NUM - 1));
   assign bus.data_valid     = dv;
   assign bus.dataa          = da;
   assign bus.datab          = db;
   assign bus.weights_loaded = (state == RUN);
   always_comb begin
      w_nxt = w;
      a_nxt = a;
      if (fire && state == LOAD_W) w_nxt[idx*WIDTH +: WIDTH] = bus.in_data;
      if (fire && state == RUN) a_nxt[idx*WIDTH +: WIDTH] = bus.in_data;
   end
   always_ff @(posedge clock or negedge clock_areset_n) begin
      if (!clock_areset_n) begin
         state <= LOAD_W;
         live  <= 1'b0;
         idx   <= '0;
         w     <= '0;
         a     <= '0;
         da    <= '0;
         db    <= '0;
         dv    <= 1'b0;
      end else begin
         live <= 1'b1;
         w    <= w_nxt;
         a    <= a_nxt;
         dv   <= last && state == RUN;
         if (bus.weight_reload) begin
            state <= LOAD_W;
            idx   <= '0;
         end else if (fire) begin
            idx <= last ? '0 : idx + 1'b1;
            if (last && state == LOAD_W) begin
               state <= RUN;
               db    <= w_nxt;
            end
            if (last && state == RUN) da <= a_nxt;
         end
      end
   end
`ifdef SOP_LOADER_NAN_FLAG_EN
   logic nan;
   assign bus.nan_seen = nan;
   always_ff @(posedge clock or negedge clock_areset_n) begin
      if (!clock_areset_n) nan <= 1'b0;
      else nan <= bus.weight_reload ? 1'b0 :
                  nan | (fire & (&bus.in_data[WIDTH-2:MANT]) & (|bus.in_data[MANT-1:0]));
   end
`else
   assign bus.nan_seen = 1'b0;
`endif
endmodule

// File: tb/tb_sop_operand_loader.sv
// tb_sop_operand_loader: directed checks of load, stream, reload, async reset and NaN flag
module tb_sop_operand_loader;
   localparam int W = 16;
   localparam int N = 9;
`ifdef SOP_LOADER_NAN_FLAG_EN
   localparam logic NAN_ON = 1'b1;
`else
   localparam logic NAN_ON = 1'b0;
`endif
   logic clock = 1'b0;
   logic clock_areset_n = 1'b0;
   int total = 0;
   int bad = 0;
   logic [N*W-1:0] ev;
   sop_operand_loader_if #(.WIDTH(W), .NUM(N)) bus ();
   sop_operand_loader #(.EXP(8), .MANT(7), .NUM(N)) dut (
      .clock(clock),
      .clock_areset_n(clock_areset_n),
      .bus(bus)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic beat(input logic [W-1:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
   endtask
   task automatic idle();
      bus.in_valid = 1'b0;
      @(posedge clock);
      #1;
   endtask
   task automatic fill(input logic [W-1:0] base, input logic step);
      for (int k = 0; k < N; k++) ev[k*W +: W] = base + (step ? W'(k) : W'(0));
   endtask
   task automatic load_weights(input logic [W-1:0] d);
      for (int i = 0; i < N; i++) beat(d);
   endtask
   initial begin
      bus.in_valid      = 1'b0;
      bus.in_data       = '0;
      bus.weight_reload = 1'b0;
      #12;
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_data_valid", bus.data_valid, 0);
      chk("rst_dataa", bus.dataa, 0);
      chk("rst_datab", bus.datab, 0);
      chk("rst_loaded", bus.weights_loaded, 0);
      chk("rst_nan", bus.nan_seen, 0);
      @(negedge clock);
      clock_areset_n = 1'b1;
      @(posedge clock);
      #1;
      chk("ready_after_rst", bus.in_ready, 1);
      // weights then one continuous activation group
      for (int i = 0; i < N; i++) begin
         beat(16'h3F80);
         chk("t1_loaded", bus.weights_loaded, (i == N - 1) ? 1 : 0);
      end
      fill(16'h3F80, 0);
      chk("t1_datab", bus.datab, ev);
      for (int i = 0; i < N; i++) begin
         beat(16'h4000 + W'(i));
         chk("t1_dv", bus.data_valid, (i == N - 1) ? 1 : 0);
      end
      fill(16'h4000, 1);
      chk("t1_dataa", bus.dataa, ev);
      idle();
      chk("t1_dv_one_cycle", bus.data_valid, 0);
      chk("t1_dataa_hold", bus.dataa, ev);
      // three groups back to back
      for (int i = 0; i < 3 * N; i++) begin
         beat(16'h4100 + W'(i));
         chk("t2_dv", bus.data_valid, (i % N == N - 1) ? 1 : 0);
         if (i % N == N - 1) begin
            fill(16'h4100 + W'(i - (N - 1)), 1);
            chk("t2_dataa", bus.dataa, ev);
         end
      end
      idle();
      chk("t2_dv_end", bus.data_valid, 0);
      // partial group discarded by reload
      for (int i = 0; i < 4; i++) beat(16'h4200 + W'(i));
      bus.in_valid      = 1'b1;
      bus.in_data       = 16'h4299;
      bus.weight_reload = 1'b1;
      #1;
      chk("t3_ready_reload", bus.in_ready, 0);
      @(posedge clock);
      #1;
      bus.weight_reload = 1'b0;
      bus.in_valid      = 1'b0;
      chk("t3_loaded_low", bus.weights_loaded, 0);
      chk("t3_dv_none", bus.data_valid, 0);
      for (int i = 0; i < N - 1; i++) beat(16'hBF80);
      fill(16'h3F80, 0);
      chk("t3_datab_shadow", bus.datab, ev);
      beat(16'hBF80);
      fill(16'hBF80, 0);
      chk("t3_datab_new", bus.datab, ev);
      for (int i = 0; i < N; i++) beat(16'h4300 + W'(i));
      fill(16'h4300, 1);
      chk("t3_dv", bus.data_valid, 1);
      chk("t3_dataa", bus.dataa, ev);
      // reload during the registered strobe does not cut it short
      bus.weight_reload = 1'b1;
      #1;
      chk("t3_dv_under_reload", bus.data_valid, 1);
      @(posedge clock);
      #1;
      bus.weight_reload = 1'b0;
      load_weights(16'h3F80);
      // gapped stream
      for (int i = 0; i < N; i++) begin
         beat(16'h4400 + W'(i));
         chk("t4_dv", bus.data_valid, (i == N - 1) ? 1 : 0);
         idle();
         chk("t4_dv_gap", bus.data_valid, 0);
      end
      fill(16'h4400, 1);
      chk("t4_dataa", bus.dataa, ev);
      // reload in the cycle of the final activation
      for (int i = 0; i < N - 1; i++) beat(16'h4500 + W'(i));
      bus.weight_reload = 1'b1;
      beat(16'h4508);
      bus.weight_reload = 1'b0;
      chk("t4_no_issue", bus.data_valid, 0);
      chk("t4_dataa_kept", bus.dataa, ev);
      load_weights(16'h3F80);
      // async reset mid-group
      for (int i = 0; i < 4; i++) beat(16'h4600 + W'(i));
      #2;
      clock_areset_n = 1'b0;
      #1;
      chk("t5_dataa_zero", bus.dataa, 0);
      chk("t5_datab_zero", bus.datab, 0);
      chk("t5_loaded_zero", bus.weights_loaded, 0);
      chk("t5_ready_zero", bus.in_ready, 0);
      @(negedge clock);
      clock_areset_n = 1'b1;
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
         beat(16'h4700 + W'(i));
         chk("t5_no_dv", bus.data_valid, 0);
      end
      fill(16'h4700, 1);
      chk("t5_datab", bus.datab, ev);
      chk("t5_loaded", bus.weights_loaded, 1);
      for (int i = 0; i < N; i++) beat(16'h4800 + W'(i));
      fill(16'h4800, 1);
      chk("t5_dv", bus.data_valid, 1);
      chk("t5_dataa", bus.dataa, ev);
      // NaN flag
      chk("t6_nan_before", bus.nan_seen, 0);
      beat(16'h7FC1);
      chk("t6_nan_set", bus.nan_seen, NAN_ON);
      for (int i = 1; i < N; i++) beat(16'h4900 + W'(i));
      chk("t6_dv", bus.data_valid, 1);
      chk("t6_nan_held", bus.nan_seen, NAN_ON);
      for (int i = 0; i < N; i++) beat(16'h4A00 + W'(i));
      chk("t6_nan_held2", bus.nan_seen, NAN_ON);
      bus.weight_reload = 1'b1;
      @(posedge clock);
      #1;
      bus.weight_reload = 1'b0;
      chk("t6_nan_cleared", bus.nan_seen, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
